// File: rtl/or_gate_arbiter.sv
// rtl/or_gate_arbiter.sv - two-requester round-robin arbiter for a shared external OR gate
//
// Purpose:
//   Two requesters share one external WIDTH-bit OR gate. Each transaction
//   runs through three states:
//     IDLE    - pick a requester.
//     DRIVE   - hold the operands on gate_a/gate_b for one cycle.
//     CAPTURE - register gate_y into y_out, pulse done, and check the gate.
//   A transaction is at most one per three cycles. The grant alternates when
//   both requesters are eligible.
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   rst_n          in   asynchronous active-low reset
//   req0, req1     in   requests; held high until the matching done
//   a0, b0         in   operands of requester 0 (WIDTH)
//   a1, b1         in   operands of requester 1 (WIDTH)
//   gnt0, gnt1     out  requester owns the gate for the current transaction
//   done0, done1   out  one-cycle pulse; y_out is valid for that requester
//   y_out          out  captured result of the last transaction (WIDTH)
//   gate_a, gate_b out  operands driven to the shared OR gate (WIDTH)
//   gate_y         in   result returned by the shared OR gate (WIDTH)
//   busy           out  high whenever the FSM is not in IDLE
//   err            out  sticky; gate result differed from gate_a | gate_b
//   txn_cnt        out  completed-transaction counter (8 bits, wraps)

module or_gate_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] gate_a,
    output logic [WIDTH-1:0] gate_b,
    input  logic [WIDTH-1:0] gate_y,
    output logic             busy,
    output logic             err,
    output logic [7:0]       txn_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;

    // Requester that owned the most recent completed transaction.
    // Reset value 1 makes requester 0 win the first contested round.
    logic last_grant;

    logic elig0;
    logic elig1;
    logic pick1;
    logic gate_bad;

    // A requester whose done is still high has just been served. It sits out
    // this edge so that a held req cannot retrigger immediately.
    assign elig0 = req0 & ~done0;
    assign elig1 = req1 & ~done1;

    // Pick requester 1 when it is the only eligible one. When both are
    // eligible, pick it if requester 0 was served last.
    assign pick1 = elig1 & (~elig0 | ~last_grant);

    // Compare the gate's answer against the operands we are driving.
    assign gate_bad = (gate_y != (gate_a | gate_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            gate_a     <= '0;
            gate_b     <= '0;
            y_out      <= '0;
            txn_cnt    <= 8'd0;
            last_grant <= 1'b1;
        end else begin
            // Done pulses last exactly one cycle.
            done0 <= 1'b0;
            done1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        // Operands are latched here. Later changes on aN/bN
                        // do not reach the gate for this transaction.
                        if (pick1) begin
                            gnt1   <= 1'b1;
                            gate_a <= a1;
                            gate_b <= b1;
                        end else begin
                            gnt0   <= 1'b1;
                            gate_a <= a0;
                            gate_b <= b0;
                        end
                        busy  <= 1'b1;
                        state <= DRIVE;
                    end
                end

                DRIVE: begin
                    // Give the external gate a full cycle to settle.
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    y_out <= gate_y;
                    if (gate_bad) begin
                        err <= 1'b1;
                    end

                    // The owner is identified by whichever grant is held.
                    // A requester dropping req mid-transaction still gets
                    // its done pulse.
                    if (gnt1) begin
                        done1      <= 1'b1;
                        last_grant <= 1'b1;
                    end else begin
                        done0      <= 1'b1;
                        last_grant <= 1'b0;
                    end

                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    busy    <= 1'b0;
                    txn_cnt <= txn_cnt + 8'd1;
                    state   <= IDLE;
                end

                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_gate_arbiter.sv
// tb/tb_or_gate_arbiter.sv - self-checking bench for or_gate_arbiter

module tb_or_gate_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1;
    logic [W-1:0] y_out, gate_a, gate_b, gate_y;
    logic         busy, err;
    logic [7:0]   txn_cnt;

    // External OR gate, with an optional stuck-output fault.
    logic         fault_en;
    logic [W-1:0] fault_val;
    assign gate_y = fault_en ? fault_val : (gate_a | gate_b);

    or_gate_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .y_out   (y_out),
        .gate_a  (gate_a),
        .gate_b  (gate_b),
        .gate_y  (gate_y),
        .busy    (busy),
        .err     (err),
        .txn_cnt (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model. The in-flight transaction is
    // described by its owner and its age in edges since the grant. It
    // completes when it is two edges old.
    int         m_owner;
    int         m_age;
    int         m_last;
    logic [W-1:0] m_a, m_b, m_y;
    bit         m_done0, m_done1, m_err;
    int         m_cnt;

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 1;
        m_a     = '0;
        m_b     = '0;
        m_y     = '0;
        m_done0 = 0;
        m_done1 = 0;
        m_err   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        bit pd0, pd1, e0, e1;
        logic [W-1:0] gy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pd0 = m_done0;
        pd1 = m_done1;
        m_done0 = 0;
        m_done1 = 0;
        if (m_owner >= 0) begin
            m_age++;
            if (m_age == 2) begin
                gy  = fault_en ? fault_val : (m_a | m_b);
                m_y = gy;
                if (gy != (m_a | m_b)) m_err = 1;
                if (m_owner == 0) m_done0 = 1; else m_done1 = 1;
                m_cnt   = (m_cnt + 1) % 256;
                m_last  = m_owner;
                m_owner = -1;
            end
        end else begin
            e0 = req0 && !pd0;
            e1 = req1 && !pd1;
            if (e0 && e1)  m_owner = 1 - m_last;
            else if (e0)   m_owner = 0;
            else if (e1)   m_owner = 1;
            if (m_owner >= 0) begin
                m_age = 0;
                m_a   = (m_owner == 0) ? a0 : a1;
                m_b   = (m_owner == 0) ? b0 : b1;
            end
        end
    endtask

    task automatic compare_all();
        check("gnt0",    32'(gnt0),    32'(m_owner == 0));
        check("gnt1",    32'(gnt1),    32'(m_owner == 1));
        check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
        check("done0",   32'(done0),   32'(m_done0));
        check("done1",   32'(done1),   32'(m_done1));
        check("busy",    32'(busy),    32'(m_owner >= 0));
        check("gate_a",  32'(gate_a),  32'(m_a));
        check("gate_b",  32'(gate_b),  32'(m_b));
        check("y_out",   32'(y_out),   32'(m_y));
        check("err",     32'(err),     32'(m_err));
        check("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
    endtask

    // Advance one clock: the model consumes the pre-edge inputs, then the
    // DUT outputs are compared 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit           who;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] a_late;
        bit           fault;
        logic [W-1:0] fval;
        logic [W-1:0] exp_y;
        bit           exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen;
        int lat;
        int dcyc[$];
        int dwho[$];

        vecs[0] = '{who: 0, a: 8'h0F, b: 8'hA0, a_late: 8'h0F, fault: 0, fval: 8'h00, exp_y: 8'hAF, exp_err: 0};
        vecs[1] = '{who: 1, a: 8'h01, b: 8'h02, a_late: 8'hFF, fault: 0, fval: 8'h00, exp_y: 8'h03, exp_err: 0};
        vecs[2] = '{who: 1, a: 8'h00, b: 8'h00, a_late: 8'h00, fault: 0, fval: 8'h00, exp_y: 8'h00, exp_err: 0};
        vecs[3] = '{who: 0, a: 8'h10, b: 8'h01, a_late: 8'h10, fault: 1, fval: 8'h00, exp_y: 8'h00, exp_err: 1};
        vecs[4] = '{who: 1, a: 8'h55, b: 8'hAA, a_late: 8'h55, fault: 0, fval: 8'h00, exp_y: 8'hFF, exp_err: 1};
        vecs[5] = '{who: 0, a: 8'hFF, b: 8'h00, a_late: 8'h00, fault: 0, fval: 8'h00, exp_y: 8'hFF, exp_err: 1};

        req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        fault_en = 0; fault_val = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Table: one transaction per entry, from reset.
        for (int i = 0; i < 6; i++) begin
            fault_en  = vecs[i].fault;
            fault_val = vecs[i].fval;
            if (vecs[i].who) begin
                req1 = 1; a1 = vecs[i].a; b1 = vecs[i].b;
            end else begin
                req0 = 1; a0 = vecs[i].a; b0 = vecs[i].b;
            end
            seen = 0;
            lat  = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                lat++;
                if (c == 0) begin
                    if (vecs[i].who) a1 = vecs[i].a_late; else a0 = vecs[i].a_late;
                end
                if ((vecs[i].who ? done1 : done0) === 1'b1) seen = 1;
            end
            check("vec_done_seen", 32'(seen), 32'd1);
            check("vec_latency",   32'(lat), 32'd3);
            check("vec_y_out",     32'(y_out), 32'(vecs[i].exp_y));
            check("vec_err",       32'(err), 32'(vecs[i].exp_err));
            check("vec_txn_cnt",   32'(txn_cnt), 32'(i + 1));
            req0 = 0; req1 = 0;
            fault_en = 0;
            tick();
        end

        // Simultaneous requests after reset: done order 0,1,0,1, 3 cycles apart.
        do_reset();
        req0 = 1; req1 = 1;
        a0 = 8'h11; b0 = 8'h22; a1 = 8'h44; b1 = 8'h88;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (done0) begin dcyc.push_back(c); dwho.push_back(0); end
            if (done1) begin dcyc.push_back(c); dwho.push_back(1); end
        end
        req0 = 0; req1 = 0;
        check("rr_count", 32'(dcyc.size()), 32'd4);
        for (int k = 0; k < 4 && k < dcyc.size(); k++) begin
            check("rr_cycle", 32'(dcyc[k]), 32'(3 * (k + 1)));
            check("rr_who",   32'(dwho[k]), 32'(k % 2));
        end
        tick(); tick();

        // Reset in the middle of DRIVE: no done and no count.
        do_reset();
        req0 = 1; a0 = 8'h3C; b0 = 8'hC3;
        tick();
        check("mid_rst_gnt", 32'(gnt0), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        req0 = 0;
        tick();
        check("mid_rst_done", 32'(done0 | done1), 32'd0);
        check("mid_rst_cnt",  32'(txn_cnt), 32'd0);
        rst_n = 1'b1;
        req1 = 1; a1 = 8'h0A; b1 = 8'h50;
        tick();
        check("post_rst_gnt1", 32'(gnt1), 32'd1);
        tick(); tick();
        check("post_rst_done1", 32'(done1), 32'd1);
        check("post_rst_y",     32'(y_out), 32'h5A);
        req1 = 0;
        tick();

        // Counter wrap: 256 back-to-back transactions.
        do_reset();
        req0 = 1; req1 = 1;
        seen = 0;
        for (int c = 0; c < 256 * 3 + 20 && seen < 256; c++) begin
            tick();
            if (done0 || done1) seen++;
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
        end
        req0 = 0; req1 = 0;
        check("wrap_done_count", 32'(seen), 32'd256);
        check("wrap_txn_cnt",    32'(txn_cnt), 32'd0);
        tick(); tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req0      = ($urandom_range(0, 3) != 0);
            req1      = ($urandom_range(0, 2) != 0);
            a0        = W'($urandom); b0 = W'($urandom);
            a1        = W'($urandom); b1 = W'($urandom);
            fault_en  = ($urandom_range(0, 15) == 0);
            fault_val = W'($urandom);
            tick();
        end
        req0 = 0; req1 = 0; fault_en = 0;
        tick(); tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/or_gate_arbiter.md
OR_GATE_ARBITER -- requirements
Module: or_gate_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1 each  request from requester 0 / 1, held high until matching done.
REQ-005 a0, b0 / a1, b1  input  WIDTH each  operands of requester 0 / 1.
REQ-006 gnt0 / gnt1  output  1 each  requester owns the shared OR gate for the current transaction.
REQ-007 done0 / done1  output  1 each  one-cycle pulse, result valid on y_out for that requester.
REQ-008 y_out  output  WIDTH  captured result of last transaction.
REQ-009 gate_a, gate_b  output  WIDTH each  operands driven to the shared OR gate.
REQ-010 gate_y  input  WIDTH  result returned by the shared OR gate.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 err  output  1  sticky flag, gate result mismatch seen.
REQ-013 txn_cnt  output  8  completed-transaction counter.

Function
REQ-014 FSM states IDLE, DRIVE, CAPTURE; DRIVE and CAPTURE each last exactly one cycle.
REQ-015 IDLE: eligible request = reqN AND NOT doneN; if none, stay IDLE, outputs hold.
REQ-016 IDLE, one eligible: at next edge grant it, latch its aN/bN into gate_a/gate_b, assert gntN, go DRIVE.
REQ-017 IDLE, both eligible: round-robin; grant the requester other than last_grant; last_grant resets to 1, so requester 0 wins first.
REQ-018 DRIVE -> CAPTURE unconditionally; gate_a/gate_b stable throughout.
REQ-019 CAPTURE edge: y_out <= gate_y; doneN pulses high for one cycle; gntN drops; last_grant <= N; txn_cnt += 1 (wraps 255 -> 0); go IDLE.
REQ-020 CAPTURE edge: if gate_y != (gate_a | gate_b), set err; err clears only on reset.
REQ-021 Latency: request sampled at edge k -> done high in cycle after edge k+2; max throughput one transaction per 3 cycles.
REQ-022 Operands latched at grant; later changes on aN/bN do not affect the transaction.
REQ-023 reqN dropping mid-transaction is ignored; transaction completes and done still pulses.
REQ-024 gnt0 and gnt1 never high together; done0 and done1 never high together.
REQ-025 gate_a/gate_b/y_out hold their values between transactions.
REQ-026 Requester whose done is high in the current cycle is not granted at the following edge, even if req still high.

Reset
REQ-027 rst_n low, at any time including mid-transaction: state IDLE; gnt0, gnt1, done0, done1, busy, err = 0; gate_a, gate_b, y_out = 0; txn_cnt = 0; last_grant = 1.
REQ-028 A transaction interrupted by reset produces no done pulse and does not increment txn_cnt.
REQ-029 First edge after rst_n release evaluates IDLE normally.

Verification
REQ-030 Single request: req0=1, a0=0x0F, b0=0xA0, correct gate -> gnt0 for 2 cycles, done0 one cycle, y_out=0xAF, txn_cnt=1, err=0.
REQ-031 Simultaneous after reset: req0=req1=1 held -> order 0, 1, 0, 1; each done 3 cycles apart; gnt never overlap.
REQ-032 Operand change after grant: req1, a1=0x01, b1=0x02, a1 changed to 0xFF in DRIVE -> y_out=0x03.
REQ-033 Faulty gate: gate_y forced 0x00 with a0=0x10, b0=0x01 -> y_out=0x00, err=1, stays 1 through later good transactions.
REQ-034 Reset mid-DRIVE: rst_n low 1 cycle during DRIVE -> no done, all outputs 0, txn_cnt=0; next req1 granted normally.
REQ-035 Counter wrap: 256 back-to-back transactions -> txn_cnt returns to 0.
